// File: rtl/mux256_scan_ctrl.sv
// Scan controller for a 256:1 bit mux: captures a word, then walks the select through all 256
// positions from start_idx and streams out the index of every set bit. Option: MUX_SCAN_ABORT_EN.
module mux256_scan_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] din,
  input  logic [7:0]   start_idx,
  output logic [7:0]   sel,
  output logic [7:0]   idx,
  output logic         idx_valid,
  input  logic         idx_ready,
  output logic         busy,
  output logic         done,
  output logic [8:0]   count
`ifdef MUX_SCAN_ABORT_EN
  ,
  input  logic         abort
`endif
);

  typedef enum logic [1:0] {StIdle, StScan, StHold, StDone} state_e;

  state_e         state_q, state_d;
  logic [255:0]   word_q, word_d;
  logic [7:0]     sel_q, sel_d;
  logic [8:0]     step_q, step_d;
  logic [7:0]     idx_q, idx_d;
  logic           idx_valid_q, idx_valid_d;
  logic [8:0]     count_q, count_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           abort_hit;
  logic           last_step;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    sel_d       = sel_q;
    step_d      = step_q;
    idx_d       = idx_q;
    idx_valid_d = idx_valid_q;
    count_d     = count_q;
`ifdef MUX_SCAN_ABORT_EN
    abort_hit   = abort;
`else
    abort_hit   = 1'b0;
`endif
    last_step   = (step_q == 9'd255);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          word_d  = din;
          sel_d   = start_idx;
          step_d  = 9'd0;
          count_d = 9'd0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (abort_hit) begin
          state_d = StIdle;
        end else if (word_q[sel_q]) begin
          idx_d       = sel_q;
          idx_valid_d = 1'b1;
          state_d     = StHold;
        end else if (!last_step) begin
          sel_d  = sel_q + 8'd1;
          step_d = step_q + 9'd1;
        end else begin
          state_d = StDone;
        end
      end
      StHold: begin
        // Abort wins over a same-cycle handshake, so that index is never counted.
        if (abort_hit) begin
          idx_valid_d = 1'b0;
          state_d     = StIdle;
        end else if (idx_ready) begin
          idx_valid_d = 1'b0;
          count_d     = count_q + 9'd1;
          if (!last_step) begin
            sel_d   = sel_q + 8'd1;
            step_d  = step_q + 9'd1;
            state_d = StScan;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      word_q      <= '0;
      sel_q       <= '0;
      step_q      <= '0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      sel_q       <= sel_d;
      step_q      <= step_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sel       = sel_q;
  assign idx       = idx_q;
  assign idx_valid = idx_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign count     = count_q;

endmodule

// File: tb/tb_mux256_scan_ctrl.sv
// Scoreboard bench for mux256_scan_ctrl: expected indices are queued at stimulus time and a
// monitor pops them on every idx handshake.
module tb_mux256_scan_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] din;
  logic [7:0]   start_idx;
  logic [7:0]   sel;
  logic [7:0]   idx;
  logic         idx_valid;
  logic         idx_ready;
  logic         busy;
  logic         done;
  logic [8:0]   count;
  logic         abort;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  mux256_scan_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .start_idx (start_idx),
    .sel       (sel),
    .idx       (idx),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .busy      (busy),
    .done      (done),
    .count     (count)
`ifdef MUX_SCAN_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  // Monitor: every handshake must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (idx_valid && idx_ready && !abort) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_idx: got %0d expected none", idx);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (idx != e) begin
            bad++;
            $display("FAIL idx_order: got %0d expected %0d", idx, e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [255:0] w, input logic [7:0] s);
    din       = w;
    start_idx = s;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // Returns edges counted after the accept edge until done is seen (cycle number = n+1).
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 2000) begin
      step();
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!idx_valid && k < 600) begin
      step();
      k++;
    end
    if (!idx_valid) check("valid_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int dc;
    logic [255:0] w;
    logic stable;
    reset     = 1'b1;
    start     = 1'b0;
    din       = '0;
    start_idx = '0;
    idx_ready = 1'b0;
    abort     = 1'b0;
    repeat (3) step();

    check("rst_sel", int'(sel), 0);
    check("rst_idx", int'(idx), 0);
    check("rst_valid", int'(idx_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_count", int'(count), 0);
    reset = 1'b0;
    step();

    // Reset while holding bit 10.
    w = '0; w[10] = 1'b1;
    do_start(w, 8'd0);
    wait_valid();
    check("midrst_idx_before", int'(idx), 10);
    reset = 1'b1;
    step();
    check("midrst_sel", int'(sel), 0);
    check("midrst_idx", int'(idx), 0);
    check("midrst_valid", int'(idx_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_count", int'(count), 0);
    reset = 1'b0;
    step();
    idx_ready = 1'b1;
    exp_q.push_back(8'd10);
    do_start(w, 8'd0);
    wait_done(n);
    check("rescan_count", int'(count), 1);
    check("rescan_q_empty", exp_q.size(), 0);
    step();

    // Zero word from 0x37.
    do_start('0, 8'h37);
    wait_done(n);
    check("zero_done_cycle", n + 1, 257);
    check("zero_count", int'(count), 0);
    check("zero_sel", int'(sel), 8'h36);
    step();
    check("zero_busy_after", int'(busy), 0);

    // Wrap-around ordering.
    w = '0; w[3] = 1'b1; w[200] = 1'b1; w[255] = 1'b1;
    exp_q.push_back(8'd255); exp_q.push_back(8'd3); exp_q.push_back(8'd200);
    dc = done_cnt;
    do_start(w, 8'd201);
    wait_done(n);
    check("wrap_count", int'(count), 3);
    repeat (3) step();
    check("wrap_done_once", done_cnt - dc, 1);
    check("wrap_q_empty", exp_q.size(), 0);

    // Backpressure on bit 5.
    idx_ready = 1'b0;
    w = '0; w[5] = 1'b1;
    do_start(w, 8'd0);
    wait_valid();
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (idx != 8'd5 || !idx_valid || count != 9'd0) stable = 1'b0;
      step();
    end
    check("bp_stable", int'(stable), 1);
    check("bp_idx_11th", int'(idx), 5);
    exp_q.push_back(8'd5);
    idx_ready = 1'b1;
    step();
    check("bp_count_after", int'(count), 1);
    check("bp_valid_after", int'(idx_valid), 0);
    wait_done(n);
    check("bp_q_empty", exp_q.size(), 0);
    step();

    // Start while busy and on the done cycle are both ignored.
    w = '0; w[7] = 1'b1; w[100] = 1'b1;
    exp_q.push_back(8'd7); exp_q.push_back(8'd100);
    do_start(w, 8'd0);
    repeat (20) step();
    do_start('1, 8'd0);
    din = '0;
    wait_done(n);
    check("sb_done_cycle", n + 1 + 21, 259);
    din = '1; start = 1'b1;
    step();
    start = 1'b0;
    check("sb_busy_after_done", int'(busy), 0);
    check("sb_count", int'(count), 2);
    check("sb_q_empty", exp_q.size(), 0);
    step();

    // All ones from 0x80.
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(8'h80 + i));
    do_start('1, 8'h80);
    wait_done(n);
    check("ones_done_cycle", n + 1, 513);
    check("ones_count", int'(count), 256);
    check("ones_q_empty", exp_q.size(), 0);
    step();

`ifdef MUX_SCAN_ABORT_EN
    // Abort on the third handoff.
    exp_q.push_back(8'h10); exp_q.push_back(8'h11);
    dc = done_cnt;
    do_start('1, 8'h10);
    n = 0;
    while (!(idx_valid && idx == 8'h12) && n < 100) begin
      step();
      n++;
    end
    check("abort_reached", int'(idx), 8'h12);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(idx_valid), 0);
    check("abort_count", int'(count), 2);
    repeat (3) step();
    check("abort_no_done", done_cnt - dc, 0);
    check("abort_q_empty", exp_q.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux256_scan_ctrl.md
# mux256_scan_ctrl

Sequencing controller for the 256-to-1 bit multiplexer datapath. It captures a 256-bit word, then steps the mux select through all 256 positions one per cycle, starting from a programmable index and wrapping around. It emits the index of every set bit over a valid/ready stream. It sits between a status/flag vector producer and a downstream consumer that services set bits in round-robin order.

## Interface
Parameters: none. Widths are fixed at 256 bits and an 8-bit index.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; takes effect at the rising edge of clk
- start  in  1  request a scan; accepted only in IDLE
- din  in  256  word to scan; sampled on the start-accept edge only
- start_idx  in  8  first bit position examined; sampled with din
- sel  out  8  current mux select (scan pointer)
- idx  out  8  index of the set bit being offered
- idx_valid  out  1  idx is valid
- idx_ready  in  1  consumer accepts idx
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a scan
- count  out  9  number of indices handed off in the current or last scan (0..256)

## Operation
- The internal 256:1 mux selects bit `word_q[sel]`, where word_q is the captured din.
- The state machine has four states: IDLE, SCAN, HOLD, DONE.
- IDLE:
  - If start=1, capture din into word_q and start_idx into sel.
  - Clear step (9-bit) and count to 0, then go to SCAN.
  - start is ignored in every other state.
- SCAN examines `word_q[sel]`.
  - Bit = 1: register idx=sel, set idx_valid=1, go to HOLD.
  - Bit = 0 and step<255: sel=sel+1 (mod 256), step+1, stay in SCAN.
  - Bit = 0 and step=255: go to DONE.
- HOLD: idx_valid stays high and idx stays stable until idx_valid&idx_ready is sampled at an edge. On that edge:
  - idx_valid drops and count increments.
  - If step<255: sel+1 (mod 256), step+1, go to SCAN.
  - If step=255: go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. count and sel hold until the next start.
- sel wraps from 255 to 0. The scan always covers exactly 256 positions regardless of start_idx.
- Changing din while busy has no effect.
- reset (including mid-scan) forces:
  - state IDLE
  - sel=0, idx=0, idx_valid=0, busy=0, done=0, count=0, word_q=0
  - any pending index is discarded.

## Timing
- All outputs are registered. The reset value of every output is 0.
- The start-accept edge is E0. busy=1 and the first SCAN cycle begin at E0+1.
- Each clear bit costs 1 cycle. Each set bit costs 1 SCAN cycle plus at least 1 HOLD cycle.
- idx_valid rises in the cycle after the SCAN cycle that found the bit.
- All-zero word: SCAN occupies cycles 1..256, done=1 in cycle 257, and busy=0 from cycle 258.
- All-ones word with idx_ready tied 1: 512 cycles of SCAN/HOLD, done in cycle 513, count=256.
- idx_ready held low stalls indefinitely in HOLD; there is no timeout.
- start asserted in the same cycle that done is high is ignored, because the block is not yet in IDLE. It is accepted from the next cycle.

## Configuration
- MUX_SCAN_ABORT_EN
- Defined:
  - Adds input port `abort` (1 bit).
  - abort=1 in SCAN or HOLD forces IDLE on the next edge, with idx_valid=0 and no done pulse.
  - count keeps the number of handoffs completed before the abort.
  - abort has priority over a same-cycle handshake: that index is not counted.
  - abort in IDLE or DONE has no effect.
- Not defined: the port does not exist, and a scan always runs to DONE.

## Test plan
- Reset mid-scan:
  - Stimulus: din bit 10 set, start_idx=0, assert reset while in HOLD.
  - Response: next cycle all outputs are 0 and state is IDLE. A later start rescans normally.
- Zero word:
  - Stimulus: din=0, start_idx=0x37.
  - Response: idx_valid is never asserted. done pulses in cycle 257 after accept, count=0, sel=0x36 at done.
- Wrap-around order:
  - Stimulus: bits {3, 200, 255} set, start_idx=201, idx_ready=1.
  - Response: idx sequence 255, 3, 200. count=3, done once.
- Backpressure:
  - Stimulus: bit 5 set, hold idx_ready=0 for 10 cycles, then 1.
  - Response: idx=5 and idx_valid stay stable for all 11 cycles. count goes 0→1 only on the handshake edge.
- Start while busy / start during done:
  - Stimulus: pulse start mid-scan with a different din, and again on the done cycle.
  - Response: both pulses ignored, and the original scan results are unchanged.
- All ones, ready=1:
  - Response: indices start_idx..start_idx+255 in order. count=256, done in cycle 513.
  - With MUX_SCAN_ABORT_EN, abort at the third handoff gives count=2, no done, busy=0 next cycle.
